// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-addressed main memory with word transfers, fixed-latency request/ready handshake
module mem_ctrl #(
  parameter int MEM_ADDR_BITS = 16,
  parameter int LATENCY       = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_in [0:3],
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_ready,
  output logic        mem_busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     ready_q, ready_d;
  logic                     we_q, we_d;
  logic [MEM_ADDR_BITS-3:0] addr_q, addr_d;
  logic [7:0]               wdata_q [0:3];
  logic [7:0]               wdata_d [0:3];
  logic [7:0]               rdata_q [0:3];
  logic [7:0]               rdata_d [0:3];
  logic [7:0]               mem [0:2**MEM_ADDR_BITS-1];
  logic                     mem_we;
  logic                     unused_addr_bits;
  // Address bits outside the implemented word range alias or are forced to alignment
  assign unused_addr_bits = ^{mem_addr[31:MEM_ADDR_BITS], mem_addr[1:0]};
  // Next state: latch operands on acceptance, count down, access when the count expires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: if (mem_req) begin
        state_d = BUSY;
        cnt_d   = 8'(LATENCY - 1);
        we_d    = mem_write_en;
        addr_d  = mem_addr[MEM_ADDR_BITS-1:2];
        wdata_d = mem_data_in;
      end
      BUSY: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      else begin
        state_d = DONE;
        ready_d = 1'b1;
        mem_we  = we_q;
        for (int i = 0; i < 4; i++) rdata_d[i] = we_q ? rdata_q[i] : mem[{addr_q, 2'(i)}];
      end
      default: state_d = IDLE;
    endcase
  end
  // Control and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '{default: 8'h00};
      rdata_q <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // Storage is never cleared; writes happen only on the completing cycle of a write
  always_ff @(posedge clk) begin
    if (mem_we) for (int i = 0; i < 4; i++) mem[{addr_q, 2'(i)}] <= wdata_q[i];
  end
  assign mem_data_out = rdata_q;
  assign mem_ready    = ready_q;
  assign mem_busy     = state_q != IDLE;
endmodule
